// File: rtl/flap_ctrl_sched_if.sv
// Signal bundle between the debounce/camera front end, the flap scheduler and
// the VGA picture logic.
interface flap_ctrl_sched_if;
    // Handshake: flap_req rises when a flap is accepted and holds until
    // flap_ack is sampled high on a clock edge. It then drops on the next cycle
    // unless a new flap is accepted on that same edge. An ack while flap_req is
    // low has no effect.
    logic       vsync;
    logic       btn_flap;
    logic       cam_valid;
    logic [9:0] cam_y;
    logic [1:0] mode_sel;
    logic       flap_ack;
    logic       flap_req;
    logic       src_cam;
    logic [1:0] src_state;
    logic [7:0] drop_cnt;

    modport slave (
        input  vsync, btn_flap, cam_valid, cam_y, mode_sel, flap_ack,
        output flap_req, src_cam, src_state, drop_cnt
    );

    modport master (
        output vsync, btn_flap, cam_valid, cam_y, mode_sel, flap_ack,
        input  flap_req, src_cam, src_state, drop_cnt
    );
endinterface

// File: rtl/flap_ctrl_sched.sv
// Chooses the button or the hand-tracking camera as the flap source once per
// frame, and issues rate-limited flap requests over a req/ack handshake.
module flap_ctrl_sched #(
    parameter int Y_TH        = 240,
    parameter int HYST        = 16,
    parameter int LOST_FRAMES = 8,
    parameter int ACQ_FRAMES  = 4,
    parameter int FLAP_GAP    = 3
) (
    input logic              vga_clk,
    input logic              sys_rst,
    flap_ctrl_sched_if.slave bus
);
    localparam logic [1:0]  ST_BTN    = 2'b00;
    localparam logic [1:0]  ST_ACQ    = 2'b01;
    localparam logic [1:0]  ST_CAM    = 2'b10;
    localparam logic [7:0]  ACQ_LAST  = 8'(ACQ_FRAMES - 2);
    localparam logic [7:0]  LOST_LAST = 8'(LOST_FRAMES - 1);
    localparam logic [7:0]  GAP_LOAD  = 8'(FLAP_GAP);
    localparam logic [10:0] Y_ARM     = 11'(Y_TH + HYST);
    localparam logic [10:0] Y_FIRE    = 11'(Y_TH);

    logic       vsync_q, tick_q, btn_q, edge_q;
    logic [1:0] mode_q, mode_now;
    logic [1:0] state_q, state_d;
    logic [7:0] acq_q, acq_d, lost_q, lost_d;
    logic [9:0] prev_y_q, prev_y_d;
    logic       prev_vld_q, prev_vld_d;
    logic [7:0] gap_q, gap_d, drop_q, drop_d;
    logic       req_q, req_d;
    logic       cam_sample, cam_ev, btn_ev, accept;

    // The mode being registered on a tick already governs that tick.
    assign mode_now = tick_q ? bus.mode_sel : mode_q;

    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        lost_d  = lost_q;
        if (tick_q) begin
            case (state_q)
                ST_BTN: begin
                    if (!mode_now[0] && bus.cam_valid) state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    // The tick that entered this state is the first valid frame.
                    if (mode_now[0] || !bus.cam_valid) state_d = ST_BTN;
                    else if (acq_q >= ACQ_LAST)        state_d = ST_CAM;
                    else                               acq_d   = acq_q + 8'd1;
                end
                ST_CAM: begin
                    if (mode_now[0])              state_d = ST_BTN;
                    else if (bus.cam_valid)       lost_d  = 8'd0;
                    else if (lost_q >= LOST_LAST) state_d = ST_BTN;
                    else                          lost_d  = lost_q + 8'd1;
                end
                default: state_d = ST_BTN;
            endcase
        end
        if (state_d != state_q) begin
            acq_d  = 8'd0;
            lost_d = 8'd0;
        end
    end

    assign cam_sample = tick_q && (state_q == ST_CAM) && bus.cam_valid && !mode_now[0];
    assign cam_ev     = cam_sample && prev_vld_q && ({1'b0, prev_y_q} >= Y_ARM)
                        && ({1'b0, bus.cam_y} < Y_FIRE);
    assign btn_ev     = edge_q && (state_q != ST_CAM) && !mode_now[1];
    assign accept     = (btn_ev || cam_ev) && (gap_q == 8'd0) && (!req_q || bus.flap_ack);

    always_comb begin
        prev_y_d   = prev_y_q;
        prev_vld_d = prev_vld_q;
        if (state_d != state_q) begin
            prev_vld_d = 1'b0;
        end else if (cam_sample) begin
            prev_y_d   = bus.cam_y;
            prev_vld_d = 1'b1;
        end

        req_d  = req_q;
        gap_d  = gap_q;
        drop_d = drop_q;
        if (accept) begin
            req_d = 1'b1;
            gap_d = GAP_LOAD;
        end else begin
            if (bus.flap_ack) req_d = 1'b0;
            if (tick_q && gap_q != 8'd0) gap_d = gap_q - 8'd1;
            if ((btn_ev || cam_ev) && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_q    <= 1'b1;
            tick_q     <= 1'b0;
            btn_q      <= 1'b0;
            edge_q     <= 1'b0;
            mode_q     <= 2'b00;
            state_q    <= ST_BTN;
            acq_q      <= 8'd0;
            lost_q     <= 8'd0;
            prev_y_q   <= 10'd0;
            prev_vld_q <= 1'b0;
            gap_q      <= 8'd0;
            drop_q     <= 8'd0;
            req_q      <= 1'b0;
        end else begin
            vsync_q    <= bus.vsync;
            tick_q     <= vsync_q && !bus.vsync;
            btn_q      <= bus.btn_flap;
            edge_q     <= bus.btn_flap && !btn_q;
            if (tick_q) mode_q <= bus.mode_sel;
            state_q    <= state_d;
            acq_q      <= acq_d;
            lost_q     <= lost_d;
            prev_y_q   <= prev_y_d;
            prev_vld_q <= prev_vld_d;
            gap_q      <= gap_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
        end
    end

    assign bus.flap_req  = req_q;
    assign bus.src_cam   = (state_q == ST_CAM);
    assign bus.src_state = state_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_flap_ctrl_sched.sv
// Directed and randomized checks of flap_ctrl_sched against a frame-level
// reference model of source selection and flap rate limiting.
module tb_flap_ctrl_sched;
    localparam int Y_TH        = 240;
    localparam int HYST        = 16;
    localparam int LOST_FRAMES = 8;
    localparam int ACQ_FRAMES  = 4;
    localparam int FLAP_GAP    = 3;
    localparam int S_BTN = 0, S_ACQ = 1, S_CAM = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flap_ctrl_sched_if bus();

    flap_ctrl_sched #(
        .Y_TH(Y_TH), .HYST(HYST), .LOST_FRAMES(LOST_FRAMES),
        .ACQ_FRAMES(ACQ_FRAMES), .FLAP_GAP(FLAP_GAP)
    ) dut (
        .vga_clk(clk),
        .sys_rst(rst),
        .bus(bus)
    );

    always #20 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame-count view of the source and flap rules.
    int m_state, m_run, m_lost, m_mode, m_prev, m_fc, m_acc, m_drop;
    bit m_have_prev, m_req;

    function automatic void model_reset();
        m_state = S_BTN; m_run = 0; m_lost = 0; m_mode = 0;
        m_prev = 0; m_have_prev = 0; m_fc = 0; m_acc = -100;
        m_drop = 0; m_req = 0;
    endfunction

    // A tick-time event is judged before that tick's own gap decrement.
    function automatic void model_event(input bit at_tick);
        int elapsed;
        elapsed = at_tick ? (m_fc - 1 - m_acc) : (m_fc - m_acc);
        if (elapsed >= FLAP_GAP && !m_req) begin
            m_req = 1;
            m_acc = m_fc;
        end else if (m_drop < 255) begin
            m_drop = m_drop + 1;
        end
    endfunction

    function automatic void model_tick(input int m, input bit v, input int y);
        int  nxt;
        bit  fire;
        bit  cam_ok;
        cam_ok = (m == 0 || m == 2);
        m_fc = m_fc + 1;
        fire = 0;
        if (m_state == S_CAM && v && cam_ok) begin
            fire = m_have_prev && (m_prev >= Y_TH + HYST) && (y < Y_TH);
            m_prev = y;
            m_have_prev = 1;
        end
        nxt = m_state;
        case (m_state)
            S_BTN: if (cam_ok && v) begin nxt = S_ACQ; m_run = 1; end
            S_ACQ: begin
                if (!cam_ok || !v) nxt = S_BTN;
                else begin
                    m_run = m_run + 1;
                    if (m_run >= ACQ_FRAMES) nxt = S_CAM;
                end
            end
            default: begin
                if (!cam_ok) nxt = S_BTN;
                else if (v) m_lost = 0;
                else begin
                    m_lost = m_lost + 1;
                    if (m_lost >= LOST_FRAMES) nxt = S_BTN;
                end
            end
        endcase
        if (nxt != m_state) begin
            m_lost = 0;
            m_have_prev = 0;
        end
        m_state = nxt;
        m_mode = m;
        if (fire) model_event(1);
    endfunction

    function automatic void model_press();
        if (m_state != S_CAM && (m_mode == 0 || m_mode == 1)) model_event(0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, 32'(bus.src_state), 32'(m_state));
        chk({tag, "_src_cam"}, 32'(bus.src_cam), 32'(m_state == S_CAM));
        chk({tag, "_req"}, 32'(bus.flap_req), 32'(m_req));
        chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic frame(input logic [1:0] m, input bit v, input logic [9:0] y, input string tag);
        @(negedge clk);
        bus.mode_sel  = m;
        bus.cam_valid = v;
        bus.cam_y     = y;
        bus.vsync     = 1'b0;
        model_tick(int'(m), v, int'(y));
        repeat (3) @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic press(input string tag);
        bit old_req;
        old_req = m_req;
        @(negedge clk);
        bus.btn_flap = 1'b1;
        model_press();
        @(negedge clk);
        bus.btn_flap = 1'b0;
        chk({tag, "_lat1"}, 32'(bus.flap_req), 32'(old_req));
        @(negedge clk);
        chk({tag, "_req"}, 32'(bus.flap_req), 32'(m_req));
        chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        bus.flap_ack = 1'b1;
        @(negedge clk);
        bus.flap_ack = 1'b0;
        m_req = 0;
        chk({tag, "_req"}, 32'(bus.flap_req), 32'(m_req));
    endtask

    initial begin
        logic [1:0] rm;
        int         r;
        bus.vsync = 1'b1; bus.btn_flap = 1'b0; bus.cam_valid = 1'b0;
        bus.cam_y = 10'd0; bus.mode_sel = 2'b00; bus.flap_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Button path in auto mode with no camera.
        frame(2'b00, 1'b0, 10'd0, "auto_idle");
        press("btn1");
        chk("btn1_rose", 32'(bus.flap_req), 32'd1);
        ack("btn1_ack");
        ack("ack_while_low");
        chk("btn1_src", 32'(bus.src_cam), 32'd0);

        // Camera acquisition takes four valid frames.
        for (int i = 0; i < 4; i++) frame(2'b00, 1'b1, 10'd300, "acq");
        chk("acq_in_cam", 32'(bus.src_cam), 32'd1);

        // Camera flap: 300 -> 200 fires; 245 -> 230 does not re-arm.
        frame(2'b00, 1'b1, 10'd300, "cam_arm");
        frame(2'b00, 1'b1, 10'd200, "cam_fire");
        chk("cam_fire_req", 32'(bus.flap_req), 32'd1);
        ack("cam_fire_ack");
        frame(2'b00, 1'b1, 10'd245, "cam_245");
        frame(2'b00, 1'b1, 10'd230, "cam_230");
        chk("cam_no_rearm", 32'(bus.flap_req), 32'd0);

        // Loss of tracking releases the camera on the eighth low frame.
        for (int i = 0; i < 8; i++) frame(2'b00, 1'b0, 10'd0, "lost");
        chk("lost_btn", 32'(bus.src_state), 32'd0);

        // Gap limiting on button presses.
        press("gap_p1");
        ack("gap_p1_ack");
        frame(2'b00, 1'b0, 10'd0, "gap_f1");
        press("gap_p2");
        chk("gap_drop1", 32'(bus.drop_cnt), 32'd1);
        frame(2'b00, 1'b0, 10'd0, "gap_f2");
        frame(2'b00, 1'b0, 10'd0, "gap_f3");
        press("gap_p3");
        chk("gap_p3_req", 32'(bus.flap_req), 32'd1);
        ack("gap_p3_ack");

        // Camera-only mode without a camera: button ignored, not dropped.
        frame(2'b10, 1'b0, 10'd0, "m10");
        press("m10_btn");
        chk("m10_drop", 32'(bus.drop_cnt), 32'd1);

        // Input disabled while in CAM drops to BTN on the next tick.
        for (int i = 0; i < 4; i++) frame(2'b00, 1'b1, 10'd300, "acq2");
        frame(2'b11, 1'b1, 10'd300, "m11");
        chk("m11_btn", 32'(bus.src_state), 32'd0);

        // Drop counter saturation.
        frame(2'b00, 1'b0, 10'd0, "sat_mode");
        press("sat_first");
        ack("sat_first_ack");
        for (int i = 0; i < 300; i++) press("sat");
        chk("sat_255", 32'(bus.drop_cnt), 32'd255);

        // Asynchronous reset mid-handshake while the camera is active.
        for (int i = 0; i < 4; i++) frame(2'b00, 1'b1, 10'd400, "acq3");
        frame(2'b00, 1'b1, 10'd400, "rst_arm");
        frame(2'b00, 1'b1, 10'd100, "rst_fire");
        chk("rst_pre_req", 32'(bus.flap_req), 32'd1);
        @(negedge clk);
        #5 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized frames, presses and acks.
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 9);
            rm = (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : (r == 8) ? 2'b01 : 2'b11;
            frame(rm, ($urandom_range(0, 9) < 8), 10'($urandom_range(0, 479)), "rnd");
            if (m_req && $urandom_range(0, 3) != 0) ack("rnd_ack");
            if ($urandom_range(0, 2) == 0) begin
                press("rnd_btn");
                if (m_req && $urandom_range(0, 1) == 1) ack("rnd_ack2");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
